// File: rtl/turing_machine_gen.sv
// Programmable Turing-machine core: serial table/tape load, then one transition per Next edge.
// Optional macro TM_FREE_RUN_EN: in RUN, step every clock until HALTED (Next ignored in RUN).
module turing_machine_gen #(
  parameter int SYM_W    = 2,
  parameter int STATE_W  = 3,
  parameter int TAPE_LEN = 16,
  parameter int STEP_W   = 16,
  localparam int ENT_W   = STATE_W + SYM_W + 2,
  localparam int HW      = $clog2(TAPE_LEN)
) (
  input  logic               clock,
  input  logic               Reset,
  input  logic [ENT_W-1:0]   input_data,
  input  logic               Next,
  input  logic               Done,
  output logic [STATE_W-1:0] next_state_out,
  output logic [1:0]         direction,
  output logic [SYM_W-1:0]   data_reg_out,
  output logic [HW-1:0]      head_pos,
  output logic [1:0]         phase,
  output logic               halted,
  output logic               fault,
  output logic [STEP_W-1:0]  step_count
);

  localparam int AW   = STATE_W + SYM_W;
  localparam int NENT = 1 << AW;
  localparam logic [STATE_W-1:0] HALT = {STATE_W{1'b1}};

  typedef enum logic [1:0] {
    PH_LOAD_TABLE = 2'd0,
    PH_LOAD_TAPE  = 2'd1,
    PH_RUN        = 2'd2,
    PH_HALTED     = 2'd3
  } phase_t;

  phase_t ph_q, ph_d;

  logic               next_q, done_q;
  logic               next_rise, done_rise;
  logic [AW-1:0]      load_addr;
  logic [HW-1:0]      tape_addr;
  logic [HW-1:0]      head;
  logic [STATE_W-1:0] state;

  logic [ENT_W-1:0]   tbl  [NENT];
  logic [SYM_W-1:0]   tape [TAPE_LEN];

  logic [SYM_W-1:0]   cur_sym;
  logic [ENT_W-1:0]   ent;
  logic [STATE_W-1:0] ent_ns;
  logic [SYM_W-1:0]   ent_ws;
  logic [1:0]         ent_dir;
  logic [HW-1:0]      head_nx;
  logic               oob;
  logic               step_en, tbl_we, tape_ld_we, enter_run;

  assign next_rise = Next & ~next_q;
  assign done_rise = Done & ~done_q;

  // Combinational lookup of the transition for the current (state, symbol)
  assign cur_sym = tape[head];
  assign ent     = tbl[{state, cur_sym}];
  assign ent_ns  = ent[ENT_W-1 -: STATE_W];
  assign ent_ws  = ent[SYM_W+1:2];
  assign ent_dir = ent[1:0];

  // Head motion; dir 2'b11 behaves as stay
  always_comb begin
    head_nx = head;
    oob     = 1'b0;
    case (ent_dir)
      2'b01: begin
        if (head == HW'(TAPE_LEN-1)) oob = 1'b1;
        else                         head_nx = head + 1'b1;
      end
      2'b10: begin
        if (head == '0) oob = 1'b1;
        else            head_nx = head - 1'b1;
      end
      default: ;
    endcase
  end

`ifdef TM_FREE_RUN_EN
  assign step_en = (ph_q == PH_RUN);
`else
  assign step_en = (ph_q == PH_RUN) && next_rise;
`endif

  // Done beats a simultaneous Next during loading
  assign tbl_we     = (ph_q == PH_LOAD_TABLE) && next_rise && !done_rise;
  assign tape_ld_we = (ph_q == PH_LOAD_TAPE)  && next_rise && !done_rise;
  assign enter_run  = (ph_q == PH_LOAD_TAPE)  && (ph_d == PH_RUN);

  always_comb begin
    ph_d = ph_q;
    case (ph_q)
      PH_LOAD_TABLE:
        if (done_rise || (tbl_we && load_addr == AW'(NENT-1))) ph_d = PH_LOAD_TAPE;
      PH_LOAD_TAPE:
        if (done_rise || (tape_ld_we && tape_addr == HW'(TAPE_LEN-1))) ph_d = PH_RUN;
      PH_RUN:
        if (step_en && (ent_ns == HALT || oob)) ph_d = PH_HALTED;
      default: ph_d = PH_HALTED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      ph_q           <= PH_LOAD_TABLE;
      next_q         <= 1'b0;
      done_q         <= 1'b0;
      load_addr      <= '0;
      tape_addr      <= '0;
      head           <= '0;
      state          <= '0;
      next_state_out <= '0;
      direction      <= '0;
      data_reg_out   <= '0;
      fault          <= 1'b0;
      step_count     <= '0;
      for (int i = 0; i < NENT; i++)     tbl[i]  <= {HALT, {SYM_W{1'b0}}, 2'b00};
      for (int i = 0; i < TAPE_LEN; i++) tape[i] <= '0;
    end else begin
      ph_q   <= ph_d;
      next_q <= Next;
      done_q <= Done;
      if (tbl_we) begin
        tbl[load_addr] <= input_data;
        load_addr      <= load_addr + 1'b1;
      end
      if (tape_ld_we) begin
        tape[tape_addr] <= input_data[SYM_W-1:0];
        tape_addr       <= tape_addr + 1'b1;
      end
      if (enter_run) begin
        head  <= '0;
        state <= '0;
      end
      // An out-of-range move still commits the write and state change
      if (step_en) begin
        tape[head]     <= ent_ws;
        state          <= ent_ns;
        head           <= head_nx;
        next_state_out <= ent_ns;
        data_reg_out   <= ent_ws;
        direction      <= ent_dir;
        if (step_count != {STEP_W{1'b1}}) step_count <= step_count + 1'b1;
        if (oob) fault <= 1'b1;
      end
    end
  end

  assign head_pos = head;
  assign phase    = ph_q;
  assign halted   = (ph_q == PH_HALTED);

endmodule

// File: doc/turing_machine_gen.md
# turing_machine_gen

Parametrised, programmable Turing-machine core; next generation of the fixed-size TuringMachine block. Loads a transition table and an initial tape serially over one input bus, then executes one transition per Next pulse. It keeps its own tape, head position, halt and fault detection, and a step counter, and drives the board-level display/status outputs.

## Interface
- SYM_W, 2: symbol width; alphabet is 2^SYM_W symbols.
- STATE_W, 3: state width. State 0 is start; state all-ones (HALT) is the halt state.
- TAPE_LEN, 16: number of tape cells; must be ≥2.
- STEP_W, 16: step counter width.
- Derived: ENT_W = STATE_W+SYM_W+2 (transition entry width); NENT = 2^(STATE_W+SYM_W).

Ports:
- clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- input_data  in  ENT_W  load data. Entry encoding: {next_state, write_sym, dir}.
- Next  in  1  level input; one action per 0→1 transition.
- Done  in  1  level input; one phase advance per 0→1 transition.
- next_state_out  out  STATE_W  state after the last step.
- direction  out  2  direction of the last step: 00 stay, 01 right, 10 left, 11 treated as stay.
- data_reg_out  out  SYM_W  symbol written by the last step.
- head_pos  out  $clog2(TAPE_LEN)  current head cell.
- phase  out  2  0 LOAD_TABLE, 1 LOAD_TAPE, 2 RUN, 3 HALTED.
- halted  out  1  machine in HALTED.
- fault  out  1  head attempted to leave the tape.
- step_count  out  STEP_W  steps executed; saturating.

## Operation
- Next and Done are each registered (next_q, done_q). A rising edge is defined as input=1 and the registered copy =0.
- **LOAD_TABLE**
  - Each Next edge writes input_data to table[load_addr], then load_addr++.
  - After entry NENT-1 is written, the block moves to LOAD_TAPE.
  - A Done edge moves to LOAD_TAPE early.
  - Table index is {state, symbol}.
- **LOAD_TAPE**
  - Each Next edge writes input_data[SYM_W-1:0] to tape[tape_addr], then tape_addr++.
  - After cell TAPE_LEN-1 is written, or on a Done edge, the block moves to RUN with head=0 and state=0.
- **RUN**, on each Next edge:
  - Reads sym = tape[head] and e = table[{state,sym}].
  - Writes tape[head] = e.write_sym and sets state = e.next_state.
  - Moves head per e.dir.
  - Registers outputs: next_state_out, data_reg_out, direction.
  - Increments step_count, saturating at all-ones.
  - If e.next_state == HALT: move to HALTED, halted=1.
  - If the move would go below 0 or above TAPE_LEN-1: the head stays, the write and state update still commit, fault=1, and the block moves to HALTED.
- **HALTED**: Next and Done are ignored. Only Reset exits.
- Reset values:
  - All outputs 0; phase=LOAD_TABLE.
  - Load addresses, head and state 0; tape cells 0.
  - Every table entry = {HALT, 0, 00}. An unprogrammed entry therefore halts the machine.

## Timing
- Load writes and RUN steps commit on the same clock edge at which the rising edge is detected. Outputs are valid immediately after that edge.
- Minimum Next period: 2 cycles (high 1, low 1). A Next held high for any length produces exactly one action.
- Simultaneous Next and Done edges:
  - In the load phases, Done wins and no write occurs.
  - In RUN, Done is ignored.
- Done in RUN or HALTED has no effect.
- Reset asserted mid-operation, in any phase, restores all reset values on that edge. Reset has priority over every other input.
- Table and tape reads are combinational from registers. No extra read latency.

## Configuration
- TM_FREE_RUN_EN defined:
  - In RUN, a step executes every clock cycle until HALTED; Next is ignored in RUN.
  - Load phases are unchanged.
- TM_FREE_RUN_EN undefined: RUN steps only on Next edges, as above.

## Test plan
Defaults: SYM_W=2, STATE_W=3, TAPE_LEN=16, so ENT_W=7 and NENT=32.
- **Reset:** assert Reset for 1 cycle -> phase=0, all outputs 0, step_count=0.
- **Single step:**
  - Load table[0] = 7'b001_01_01, then Done.
  - Load tape [0,2,1], then Done. Expect phase=2.
  - One Next pulse -> next_state_out=1, data_reg_out=1, direction=01, head_pos=1, step_count=1.
- **Held Next:** hold Next high for 5 cycles in RUN -> step_count increments by exactly 1.
- **Left edge:**
  - Program table[0] = 7'b000_11_10 (left). Tape empty.
  - Next -> fault=1, halted=1, phase=3, head_pos=0, data_reg_out=3.
  - A further Next -> no output change.
- **Default halt:** Done, Done with an empty table, then Next -> next_state_out=7, halted=1, step_count=1.
- **Auto-advance:**
  - 32 Next edges in LOAD_TABLE -> phase=1 with no Done.
  - 16 Next edges -> phase=2.
  - Reset mid-LOAD_TAPE -> phase=0 and tape cleared.
